out_buffer: RTL and testbench

Result-side output stage of the DMA test datapath. It collects 8-bit results from the compute core during a frame and stores them in a block-RAM buffer. At frame end it streams them to the DMA S2MM channel as a 32-bit AXI-Stream master, with `tlast` on the final beat. After the final handshake it pulses `o_last`, which drives the input buffer's `i_last` and returns that stage from SEND_DATA to IDLE.

---
 rtl/dma_test_pkg.sv | 11 +
 rtl/out_buffer_if.sv | 23 ++
 rtl/out_buffer_ram.sv | 22 ++
 rtl/out_buffer.sv | 128 ++++++++++++
 tb/tb_out_buffer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_test_pkg.sv
// dma_test_pkg: shared state encoding, stream widths and beat record for the DMA test datapath
package dma_test_pkg;
    typedef enum logic [1:0] {OB_IDLE, OB_COLLECT, OB_SEND} ob_state_t;
    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_STRB_W = 4;
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_STRB_W-1:0] strb;
        logic                   last;
    } ob_beat_t;
endpackage

// File: rtl/out_buffer_if.sv
// out_buffer_if: result-byte input, AXI-Stream master output and status of the out_buffer stage
interface out_buffer_if;
    import dma_test_pkg::*;
    logic                   i_res_valid;
    logic [7:0]             i_res_data;
    logic                   o_res_ready;
    logic                   i_frame_done;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [AXIS_DATA_W-1:0] m_axis_tdata;
    logic [AXIS_STRB_W-1:0] m_axis_tstrb;
    logic                   m_axis_tlast;
    logic                   o_last;
    logic [3:0]             leds;
    modport master (
        input  i_res_valid, i_res_data, i_frame_done, m_axis_tready,
        output o_res_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, o_last, leds
    );
    modport slave (
        output i_res_valid, i_res_data, i_frame_done, m_axis_tready,
        input  o_res_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, o_last, leds
    );
endinterface

// File: rtl/out_buffer_ram.sv
// out_buffer_ram: simple dual-port RAM with per-lane byte write enables and a registered read port
module out_buffer_ram #(
    parameter int DEPTH = 256,
    parameter int LANES = 4,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic [LANES-1:0]   we,
    input  logic [AW-1:0]      waddr,
    input  logic [LANES*8-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [LANES*8-1:0] rdata
);
    logic [LANES*8-1:0] mem [DEPTH];

    // lane-masked write and one-cycle registered read
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (we[l]) mem[waddr][l*8 +: 8] <= wdata[l*8 +: 8];
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/out_buffer.sv
// out_buffer: collects result bytes per frame and streams them out as AXI-Stream; OUT_BUFFER_PACK_EN packs 4 bytes per beat
module out_buffer import dma_test_pkg::*; #(
    parameter int RES_DEPTH = 1024,
    parameter int CNT_W     = 16
) (
    input logic        clk,
    input logic        rst,
    out_buffer_if.master bus
);
`ifdef OUT_BUFFER_PACK_EN
    localparam int LANES = 4;
`else
    localparam int LANES = 1;
`endif
    localparam int LSH   = $clog2(LANES);
    localparam int WORDS = (RES_DEPTH + LANES - 1) / LANES;
    localparam int AW    = WORDS > 1 ? $clog2(WORDS) : 1;

    ob_state_t          state, nxt;
    logic [CNT_W-1:0]   byte_cnt, words, rem, rd_idx, rd_idx_q;
    logic [CNT_W:0]     cnt_up;
    logic               full, accept, overflow, last_q;
    logic               rd_v, rd_last, issue, pop, out_free, fin;
    logic [1:0]         occ;
    logic [LANES-1:0]   we, last_mask, mask;
    logic [LANES*8-1:0] rdata;
    ob_beat_t           rd_beat, out_q, sk_q;
    logic               out_v, sk_v;

    assign full            = byte_cnt == CNT_W'(RES_DEPTH);
    assign bus.o_res_ready = state != OB_SEND && !full;
    assign accept          = bus.i_res_valid && bus.o_res_ready;
    assign rem             = byte_cnt & CNT_W'(LANES - 1);
    assign we              = accept ? LANES'(1) << rem : '0;
    assign cnt_up          = {1'b0, byte_cnt} + (CNT_W+1)'(LANES - 1);
    assign words           = CNT_W'(cnt_up >> LSH);
    assign last_mask       = rem == '0 ? '1 : LANES'((1 << rem) - 1);

    // the read pipeline holds at most two beats (output + skid); only fetch when the in-flight word will fit
    assign pop      = out_v && bus.m_axis_tready;
    assign out_free = !out_v || bus.m_axis_tready;
    assign fin      = state == OB_SEND && pop && out_q.last;
    assign occ      = 2'(out_v) + 2'(sk_v) + 2'(rd_v);
    assign issue    = state == OB_SEND && rd_idx < words && (occ - 2'(pop)) < 2'd2;

    out_buffer_ram #(.DEPTH(WORDS), .LANES(LANES), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (AW'(byte_cnt >> LSH)),
        .wdata ({LANES{bus.i_res_data}}),
        .raddr (AW'(rd_idx)),
        .rdata (rdata)
    );

    // shape the word just read into a beat; stale lanes of the final word are zeroed
    always_comb begin
        rd_last      = rd_idx_q == words - 1'b1;
        mask         = rd_last ? last_mask : '1;
        rd_beat      = '0;
        rd_beat.strb = AXIS_STRB_W'(mask);
        rd_beat.last = rd_last;
        for (int l = 0; l < LANES; l++)
            rd_beat.data[l*8 +: 8] = mask[l] ? rdata[l*8 +: 8] : 8'h0;
    end

    // state register
    always_ff @(posedge clk) state <= rst ? OB_IDLE : nxt;

    // frame sequencing; a byte together with frame_done in IDLE forms a one-byte frame
    always_comb begin
        nxt = state;
        unique case (state)
            OB_IDLE:    nxt = bus.i_res_valid ? (bus.i_frame_done ? OB_SEND : OB_COLLECT) : OB_IDLE;
            OB_COLLECT: nxt = bus.i_frame_done ? OB_SEND : OB_COLLECT;
            OB_SEND:    nxt = fin ? OB_IDLE : OB_SEND;
            default:    nxt = OB_IDLE;
        endcase
    end

    // byte count, sticky overflow and the end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            overflow <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            byte_cnt <= fin ? '0 : byte_cnt + CNT_W'(accept);
            overflow <= (state == OB_IDLE && bus.i_res_valid) ? 1'b0
                      : overflow || (state == OB_COLLECT && bus.i_res_valid && full);
            last_q   <= fin || (state == OB_IDLE && bus.i_frame_done && !bus.i_res_valid);
        end
    end

    // fetch counter, output register and skid entry; all flushed outside SEND
    always_ff @(posedge clk) begin
        if (rst || state != OB_SEND) begin
            rd_idx   <= '0;
            rd_idx_q <= '0;
            rd_v     <= 1'b0;
            out_v    <= 1'b0;
            sk_v     <= 1'b0;
            out_q    <= '0;
            sk_q     <= '0;
        end else begin
            rd_idx   <= rd_idx + CNT_W'(issue);
            rd_idx_q <= rd_idx;
            rd_v     <= issue;
            if (out_free) begin
                out_v <= sk_v || rd_v;
                out_q <= sk_v ? sk_q : rd_v ? rd_beat : '0;
                if (sk_v) begin
                    sk_v <= rd_v;
                    sk_q <= rd_v ? rd_beat : '0;
                end
            end else if (rd_v) begin
                sk_v <= 1'b1;
                sk_q <= rd_beat;
            end
        end
    end

    assign bus.m_axis_tvalid = out_v;
    assign bus.m_axis_tdata  = out_q.data;
    assign bus.m_axis_tstrb  = out_q.strb;
    assign bus.m_axis_tlast  = out_q.last;
    assign bus.o_last        = last_q;
    assign bus.leds          = {state == OB_COLLECT, state == OB_SEND, 1'b0, overflow};
endmodule

// File: tb/tb_out_buffer.sv
// tb_out_buffer: directed frames against a byte-queue model of out_buffer, checked every cycle
module tb_out_buffer;
    import dma_test_pkg::*;
    localparam int DEPTH = 16;
`ifdef OUT_BUFFER_PACK_EN
    localparam int L = 4;
`else
    localparam int L = 1;
`endif

    logic       clk = 1'b0, rst = 1'b1;
    logic       res_valid = 1'b0, frame_done = 1'b0, tready = 1'b1;
    logic [7:0] res_data = 8'h0;
    int         total = 0, bad = 0, tr_mode = 0, tr_i = 0;
    bit         chk_en = 1'b0;

    out_buffer_if bus();
    assign bus.i_res_valid   = res_valid;
    assign bus.i_res_data    = res_data;
    assign bus.i_frame_done  = frame_done;
    assign bus.m_axis_tready = tready;

    out_buffer #(.RES_DEPTH(DEPTH), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: phase 0 idle, 1 collecting, 2 sending
    int         m_phase = 0;
    logic [7:0] m_bytes[$];
    ob_beat_t   m_beats[$];
    ob_beat_t   log_q[$];
    bit         m_olast = 1'b0, m_ovf = 1'b0, prev_stall = 1'b0;
    ob_beat_t   prev_beat;

    function automatic void build();
        int n = (m_bytes.size() + L - 1) / L;
        for (int w = 0; w < n; w++) begin
            ob_beat_t b = '0;
            for (int l = 0; l < L; l++)
                if (w * L + l < m_bytes.size()) begin
                    b.data[l*8 +: 8] = m_bytes[w * L + l];
                    b.strb[l] = 1'b1;
                end
            b.last = (w == n - 1);
            m_beats.push_back(b);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        tready = (tr_mode == 1) ? (tr_i % 3 == 0) : 1'b1;
        tr_i++;
    end

    always @(negedge clk) if (chk_en) begin
        ob_beat_t act;
        bit exp_ready;
        int ph;
        exp_ready = m_phase != 2 && m_bytes.size() < DEPTH;
        chk("o_res_ready", bus.o_res_ready, exp_ready);
        chk("leds", bus.leds, {m_phase == 1, m_phase == 2, 1'b0, m_ovf});
        chk("o_last", bus.o_last, m_olast);
        act = {bus.m_axis_tdata, bus.m_axis_tstrb, bus.m_axis_tlast};
        if (prev_stall) begin
            chk("tvalid_held", bus.m_axis_tvalid, 1'b1);
            chk("tdata_held", act.data, prev_beat.data);
            chk("tstrb_last_held", {act.strb, act.last}, {prev_beat.strb, prev_beat.last});
        end
        if (bus.m_axis_tvalid) begin
            chk("beat_expected", m_beats.size() != 0, 1'b1);
            if (m_beats.size() != 0) begin
                chk("tdata", act.data, m_beats[0].data);
                chk("tstrb", act.strb, m_beats[0].strb);
                chk("tlast", act.last, m_beats[0].last);
            end
        end
        prev_stall = bus.m_axis_tvalid && !tready;
        prev_beat  = act;
        if (rst) begin
            m_phase = 0;
            m_bytes.delete();
            m_beats.delete();
            m_olast = 1'b0;
            m_ovf = 1'b0;
            prev_stall = 1'b0;
        end else begin
            ph = m_phase;
            m_olast = 1'b0;
            if (bus.m_axis_tvalid && tready && m_beats.size() != 0) begin
                log_q.push_back(act);
                if (m_beats[0].last) begin
                    m_phase = 0;
                    m_bytes.delete();
                    m_olast = 1'b1;
                end
                void'(m_beats.pop_front());
            end
            if (res_valid && exp_ready) m_bytes.push_back(res_data);
            if (ph == 0) begin
                if (res_valid) begin
                    m_ovf = 1'b0;
                    m_phase = frame_done ? 2 : 1;
                end else if (frame_done) m_olast = 1'b1;
            end else if (ph == 1) begin
                if (res_valid && !exp_ready) m_ovf = 1'b1;
                if (frame_done) m_phase = 2;
            end
            if (ph != 2 && m_phase == 2) build();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] b, input bit fd);
        res_valid = 1'b1;
        res_data = b;
        frame_done = fd;
        tick();
        res_valid = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic done_pulse();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_phase != 0 || m_beats.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, n < 500, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("rst_tdata", bus.m_axis_tdata, 32'h0);
        chk("rst_tstrb_tlast", {bus.m_axis_tstrb, bus.m_axis_tlast}, 5'h0);
        chk("rst_ready", bus.o_res_ready, 1'b1);
        chk("rst_leds_olast", {bus.leds, bus.o_last}, 5'h0);
        tick();
        rst = 1'b0;
        tick();

        // eight bytes, separate frame_done, latency and o_last timing
        log_q.delete();
        for (int i = 1; i <= 8; i++) offer(8'(i), 1'b0);
        done_pulse();
        @(negedge clk);
        chk("t1_c0_tvalid", bus.m_axis_tvalid, 1'b0);
        @(negedge clk);
        chk("t1_c1_tvalid", bus.m_axis_tvalid, 1'b0);
        @(negedge clk);
        chk("t1_c2_tvalid", bus.m_axis_tvalid, 1'b1);
`ifdef OUT_BUFFER_PACK_EN
        chk("t1_first_data", bus.m_axis_tdata, 32'h04030201);
        repeat (2) @(negedge clk);
`else
        chk("t1_first_data", bus.m_axis_tdata, 32'h00000001);
        repeat (8) @(negedge clk);
`endif
        chk("t1_o_last_cycle", bus.o_last, 1'b1);
        wait_idle("t1");
`ifdef OUT_BUFFER_PACK_EN
        chk("t1_beats", log_q.size(), 2);
        chk("t1_b1_data", log_q[1].data, 32'h08070605);
        chk("t1_b1_strb_last", {log_q[1].strb, log_q[1].last}, {4'hF, 1'b1});
        chk("t1_b0_strb_last", {log_q[0].strb, log_q[0].last}, {4'hF, 1'b0});
`else
        chk("t1_beats", log_q.size(), 8);
        chk("t1_b7_data", log_q[7].data, 32'h00000008);
        chk("t1_b7_strb_last", {log_q[7].strb, log_q[7].last}, {4'h1, 1'b1});
`endif

        // five bytes, frame_done with the last byte; stale lanes must read as zero
        log_q.delete();
        for (int i = 0; i < 5; i++) offer(8'hA0 + 8'(i), i == 4);
        wait_idle("t2");
`ifdef OUT_BUFFER_PACK_EN
        chk("t2_beats", log_q.size(), 2);
        chk("t2_b0_data", log_q[0].data, 32'hA3A2A1A0);
        chk("t2_b1_data", log_q[1].data, 32'h000000A4);
        chk("t2_b1_strb_last", {log_q[1].strb, log_q[1].last}, {4'h1, 1'b1});
`else
        chk("t2_beats", log_q.size(), 5);
        chk("t2_b4_data", log_q[4].data, 32'h000000A4);
        chk("t2_b4_strb_last", {log_q[4].strb, log_q[4].last}, {4'h1, 1'b1});
`endif

        // twelve bytes with tready stalling
        log_q.delete();
        tr_mode = 1;
        for (int i = 0; i < 12; i++) offer(8'h10 + 8'(i), 1'b0);
        done_pulse();
        wait_idle("t3");
        tr_mode = 0;
`ifdef OUT_BUFFER_PACK_EN
        chk("t3_beats", log_q.size(), 3);
        chk("t3_b2_data", log_q[2].data, 32'h1B1A1918);
`else
        chk("t3_beats", log_q.size(), 12);
        chk("t3_b11_data", log_q[11].data, 32'h0000001B);
`endif

        // overflow: DEPTH+3 bytes offered
        log_q.delete();
        for (int i = 0; i < DEPTH + 3; i++) offer(8'h30 + 8'(i), 1'b0);
        @(negedge clk);
        chk("t4_full_ready", bus.o_res_ready, 1'b0);
        chk("t4_ovf_led", bus.leds[0], 1'b1);
        tick();
        done_pulse();
        wait_idle("t4");
        chk("t4_beats", log_q.size(), DEPTH / L);
        chk("t4_ovf_sticky", bus.leds[0], 1'b1);
`ifdef OUT_BUFFER_PACK_EN
        chk("t4_last_data", log_q[3].data, 32'h3F3E3D3C);
`else
        chk("t4_last_data", log_q[15].data, 32'h0000003F);
`endif

        // reset while the second beat is presented
        log_q.delete();
        for (int i = 0; i < 16; i++) offer(8'h50 + 8'(i), i == 15);
        begin
            int n = 0;
            while (log_q.size() < 1 && n < 100) begin
                tick();
                n++;
            end
            chk("t5_first_beat_wait", n < 100, 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_tvalid", bus.m_axis_tvalid, 1'b0);
        chk("t5_tdata", bus.m_axis_tdata, 32'h0);
        chk("t5_leds_olast", {bus.leds, bus.o_last}, 5'h0);
        chk("t5_ready", bus.o_res_ready, 1'b1);
        repeat (3) tick();
        log_q.delete();
        for (int i = 0; i < 4; i++) offer(8'hC0 + 8'(i), i == 3);
        wait_idle("t5");
`ifdef OUT_BUFFER_PACK_EN
        chk("t5_beats", log_q.size(), 1);
        chk("t5_b0_data", log_q[0].data, 32'hC3C2C1C0);
        chk("t5_b0_strb_last", {log_q[0].strb, log_q[0].last}, {4'hF, 1'b1});
`else
        chk("t5_beats", log_q.size(), 4);
        chk("t5_b3_data", log_q[3].data, 32'h000000C3);
`endif

        // empty frame
        log_q.delete();
        done_pulse();
        @(negedge clk);
        chk("t6_o_last", bus.o_last, 1'b1);
        chk("t6_tvalid", bus.m_axis_tvalid, 1'b0);
        repeat (5) tick();
        chk("t6_beats", log_q.size(), 0);

        // three bytes
        log_q.delete();
        offer(8'h55, 1'b0);
        offer(8'h66, 1'b0);
        offer(8'h77, 1'b1);
        wait_idle("t7");
`ifdef OUT_BUFFER_PACK_EN
        chk("t7_beats", log_q.size(), 1);
        chk("t7_b0_data", log_q[0].data, 32'h00776655);
        chk("t7_b0_strb", log_q[0].strb, 4'h7);
`else
        chk("t7_beats", log_q.size(), 3);
        chk("t7_b0_data", log_q[0].data, 32'h00000055);
        chk("t7_b2_data", log_q[2].data, 32'h00000077);
        chk("t7_strb", {log_q[0].strb, log_q[1].strb, log_q[2].strb}, 12'h111);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
